// File: rtl/pq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pq_pkg
//  Description : Shared types for the priority-queue core and its command
//                front-end: key/value entry, command opcode, queued command
//                word and the scheduler state encoding.
//  Contents    : kv_t          key/value entry exchanged with the core
//                op_t          command opcode (NOP/ENQ/DEQ/REP)
//                pq_cmd_t      one command FIFO entry {op, kv}
//                sched_state_t scheduler FSM states
//  Revision    : 1.0  initial release
// ============================================================================
package pq_pkg;

   localparam int KEY_W = 8;
   localparam int VAL_W = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ENQ = 2'd1,
      OP_DEQ = 2'd2,
      OP_REP = 2'd3
   } op_t;

   typedef struct packed {
      op_t op;
      kv_t kv;
   } pq_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/pq_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pq_cmd_fifo
//  Description : Small command FIFO in front of the scheduler. The head entry
//                is a combinational read of the storage array, so the
//                scheduler can decide on it in the same cycle it appears.
//  Ports       : clk     in   clock
//                rst     in   asynchronous active-high reset (empties FIFO)
//                push_i  in   write din_i at the tail
//                din_i   in   command word to write
//                pop_i   in   discard the head entry (ignored when empty)
//                head_o  out  current head entry
//                full_o  out  DEPTH entries stored
//                empty_o out  no entries stored
//  Revision    : 1.0  initial release
// ============================================================================
module pq_cmd_fifo
   import pq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push_i,
   input  pq_cmd_t din_i,
   input  logic    pop_i,
   output pq_cmd_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int AW = $clog2(DEPTH);

   pq_cmd_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [AW:0]     count_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal when the head leaves on the same edge.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
   // modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once count_q covers them.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule
`default_nettype wire

// File: rtl/pq_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pq_cmd_sched
//  Description : Command front-end for the priority-queue core. Buffers
//                ENQ/DEQ/REPLACE commands, issues each one to the core only
//                when it is legal, and returns dequeued entries through a
//                valid/ready result register.
//  Ports       : clk, rst                 clock, async active-high reset
//                cmd_valid/ready/op/kv    producer command channel
//                res_valid/ready/kv       consumer result channel
//                err                      pulse: command retired with no core op
//                pq_kvi/enq/deq/replace   core command strobes and data
//                pq_kvo/busy/full/empty   core status and top-of-queue entry
//  Revision    : 1.0  initial release
// ============================================================================
module pq_cmd_sched
   import pq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic cmd_valid,
   output logic cmd_ready,
   input  op_t  cmd_op,
   input  kv_t  cmd_kv,
   output logic res_valid,
   input  logic res_ready,
   output kv_t  res_kv,
   output logic err,
   output kv_t  pq_kvi,
   output logic pq_enq,
   output logic pq_deq,
   output logic pq_replace,
   input  kv_t  pq_kvo,
   input  logic pq_busy,
   input  logic pq_full,
   input  logic pq_empty
);

   sched_state_t state_q, state_d;

   pq_cmd_t head;
   logic    fifo_full;
   logic    fifo_empty;
   logic    fifo_push;
   logic    fifo_pop;

   logic    pq_enq_q, pq_enq_d;
   logic    pq_deq_q, pq_deq_d;
   logic    pq_rep_q, pq_rep_d;
   logic    err_q,    err_d;
   logic    res_valid_q;
   kv_t     res_kv_q;
   kv_t     pq_kvi_q;

   assign cmd_ready = ~fifo_full;
   assign fifo_push = cmd_valid & cmd_ready;

   pq_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   ({cmd_op, cmd_kv}),
      .pop_i   (fifo_pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Issue decision. Everything here is evaluated only in IDLE; the strobes
   // it produces are registered, so the core sees them one cycle later while
   // the FSM sits in SETTLE.
   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      pq_enq_d = 1'b0;
      pq_deq_d = 1'b0;
      pq_rep_d = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !pq_busy) begin
               case (head.op)
                  OP_ENQ: begin
                     // A full core stalls the head; the command is never dropped.
                     if (!pq_full) begin
                        pq_enq_d = 1'b1;
                        fifo_pop = 1'b1;
                        state_d  = ST_SETTLE;
                     end
                  end
                  OP_DEQ, OP_REP: begin
                     if (pq_empty) begin
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                     end else if (!res_valid_q) begin
                        // Holding off while a result is pending guarantees the
                        // capture below never collides with a consumer clear.
                        fifo_pop = 1'b1;
                        state_d  = ST_SETTLE;
                        if (head.op == OP_DEQ) pq_deq_d = 1'b1;
                        else                   pq_rep_d = 1'b1;
                     end
                  end
                  default: begin
                     fifo_pop = 1'b1;
                     err_d    = 1'b1;
                  end
               endcase
            end
         end
         // One dead cycle so the core has time to raise busy before WAIT looks.
         ST_SETTLE: state_d = ST_WAIT;
         ST_WAIT:   if (!pq_busy) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pq_enq_q    <= 1'b0;
         pq_deq_q    <= 1'b0;
         pq_rep_q    <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_kv_q    <= '0;
         pq_kvi_q    <= '0;
      end else begin
         state_q  <= state_d;
         pq_enq_q <= pq_enq_d;
         pq_deq_q <= pq_deq_d;
         pq_rep_q <= pq_rep_d;
         err_q    <= err_d;
         if (pq_enq_d || pq_rep_d) pq_kvi_q <= head.kv;
         // The top entry is taken from the core before it acts on the strobe.
         if (pq_deq_d || pq_rep_d) begin
            res_valid_q <= 1'b1;
            res_kv_q    <= pq_kvo;
         end else if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end

   assign res_valid  = res_valid_q;
   assign res_kv     = res_kv_q;
   assign err        = err_q;
   assign pq_kvi     = pq_kvi_q;
   assign pq_enq     = pq_enq_q;
   assign pq_deq     = pq_deq_q;
   assign pq_replace = pq_rep_q;

endmodule
`default_nettype wire

// File: tb/tb_pq_cmd_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pq_cmd_sched
//  Description : Self-checking bench for pq_cmd_sched. A behavioural priority
//                queue core sits behind the DUT; a sorted-list reference model
//                predicts every result, every pq_kvi value and the number of
//                strobes of each kind. Directed scenarios are followed by a
//                randomized command stream with random result backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pq_cmd_sched;
   import pq_pkg::*;

   localparam int CAP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic cmd_valid = 1'b0;
   logic cmd_ready;
   op_t  cmd_op = OP_NOP;
   kv_t  cmd_kv = '0;
   logic res_valid;
   logic res_ready = 1'b1;
   kv_t  res_kv;
   logic err;
   kv_t  pq_kvi;
   logic pq_enq, pq_deq, pq_replace;
   kv_t  pq_kvo = '0;
   logic pq_busy = 1'b0;
   logic pq_full = 1'b0;
   logic pq_empty = 1'b1;

   pq_cmd_sched #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_kv     (cmd_kv),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_kv     (res_kv),
      .err        (err),
      .pq_kvi     (pq_kvi),
      .pq_enq     (pq_enq),
      .pq_deq     (pq_deq),
      .pq_replace (pq_replace),
      .pq_kvo     (pq_kvo),
      .pq_busy    (pq_busy),
      .pq_full    (pq_full),
      .pq_empty   (pq_empty)
   );

   int n_compared = 0;
   int n_mismatched = 0;

   task automatic chk(string tag, logic [31:0] act, logic [31:0] expv);
      n_compared++;
      if (act !== expv) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expv, $time);
      end
   endtask

   function automatic kv_t mk(int k, int v);
      kv_t r;
      r.key = 8'(k);
      r.val = 8'(v);
      return r;
   endfunction

   // ---------------- behavioural core ----------------
   kv_t  core_q[$];
   int   busy_cnt = 0;
   int   lat_min  = 0;
   int   lat_max  = 3;
   logic full_ovr = 1'b0;

   function automatic int core_min();
      int m = 0;
      for (int i = 1; i < core_q.size(); i++)
         if (core_q[i].key < core_q[m].key) m = i;
      return m;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_q.delete();
         busy_cnt = 0;
         pq_busy  <= 1'b0;
         pq_empty <= 1'b1;
         pq_full  <= 1'b0;
         pq_kvo   <= '0;
      end else begin
         if (pq_enq) core_q.push_back(pq_kvi);
         else if (pq_deq && core_q.size() > 0) core_q.delete(core_min());
         else if (pq_replace && core_q.size() > 0) begin
            core_q.delete(core_min());
            core_q.push_back(pq_kvi);
         end
         if (pq_enq || pq_deq || pq_replace) busy_cnt = int'($urandom_range(lat_max, lat_min));
         else if (busy_cnt > 0) busy_cnt--;
         pq_busy  <= (busy_cnt > 0);
         pq_empty <= (core_q.size() == 0);
         pq_full  <= (core_q.size() >= CAP) && !full_ovr;
         pq_kvo   <= (core_q.size() > 0) ? core_q[core_min()] : '0;
      end
   end

   // ---------------- reference model ----------------
   kv_t ref_q[$];       // kept sorted by key, equal keys in arrival order
   kv_t exp_res[$];
   kv_t exp_kvi[$];
   kv_t got_res[$];
   int  exp_enq = 0, exp_deq = 0, exp_rep = 0, exp_err = 0;

   task automatic ref_insert(kv_t kv);
      int i = 0;
      while (i < ref_q.size() && ref_q[i].key <= kv.key) i++;
      ref_q.insert(i, kv);
   endtask

   // ---------------- monitor ----------------
   int n_enq = 0, n_deq = 0, n_rep = 0, n_err = 0;
   int cyc = 0, last_deq_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (pq_enq) n_enq++;
         if (pq_deq) begin n_deq++; last_deq_cyc = cyc; end
         if (pq_replace) n_rep++;
         if (err) n_err++;
         if (pq_enq || pq_deq || pq_replace || err)
            chk("one_strobe", 32'(pq_enq) + 32'(pq_deq) + 32'(pq_replace) + 32'(err), 32'd1);
         if (pq_enq || pq_replace) begin
            if (exp_kvi.size() == 0) chk("kvi_unexpected", 32'd1, 32'd0);
            else chk("pq_kvi", {16'd0, pq_kvi}, {16'd0, exp_kvi.pop_front()});
         end
         if (res_valid && res_ready) begin
            got_res.push_back(res_kv);
            if (exp_res.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
            else chk("res_kv", {16'd0, res_kv}, {16'd0, exp_res.pop_front()});
         end
      end
   end

   // ---------------- result backpressure driver ----------------
   logic rand_rr = 1'b0;
   logic rr_val  = 1'b1;
   always @(posedge clk) begin
      #1;
      res_ready = rand_rr ? 1'($urandom_range(0, 1)) : rr_val;
   end

   // ---------------- stimulus tasks ----------------
   task automatic send(op_t op, kv_t kv);
      int t = 0;
      cmd_op = op;
      cmd_kv = kv;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
      if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic cmd(op_t op, kv_t kv);
      case (op)
         OP_ENQ: begin ref_insert(kv); exp_kvi.push_back(kv); exp_enq++; end
         OP_DEQ: begin
            if (ref_q.size() == 0) exp_err++;
            else begin exp_res.push_back(ref_q.pop_front()); exp_deq++; end
         end
         OP_REP: begin
            if (ref_q.size() == 0) exp_err++;
            else begin
               exp_res.push_back(ref_q.pop_front());
               ref_insert(kv);
               exp_kvi.push_back(kv);
               exp_rep++;
            end
         end
         default: exp_err++;
      endcase
      send(op, kv);
   endtask

   task automatic drain(string tag);
      int t = 0;
      while ((n_enq != exp_enq || n_deq != exp_deq || n_rep != exp_rep || n_err != exp_err)
             && t < 3000) begin
         @(posedge clk); t++;
      end
      repeat (8) @(posedge clk);
      #1;
      chk({tag, "_enq"}, 32'(n_enq), 32'(exp_enq));
      chk({tag, "_deq"}, 32'(n_deq), 32'(exp_deq));
      chk({tag, "_rep"}, 32'(n_rep), 32'(exp_rep));
      chk({tag, "_err"}, 32'(n_err), 32'(exp_err));
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int base;
      int rr_cyc;
      int r;
      op_t op;

      // reset state
      #22;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_strobes", 32'(pq_enq) + 32'(pq_deq) + 32'(pq_replace), 32'd0);
      chk("rst_pq_kvi", {16'd0, pq_kvi}, 32'd0);
      chk("rst_res_kv", {16'd0, res_kv}, 32'd0);
      rst = 1'b0;
      cycles(1);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // 1: ENQ 5,2,9 then DEQ x3
      got_res.delete();
      cmd(OP_ENQ, mk(5, 8'h50));
      cmd(OP_ENQ, mk(2, 8'h20));
      cmd(OP_ENQ, mk(9, 8'h90));
      cmd(OP_DEQ, '0);
      cmd(OP_DEQ, '0);
      cmd(OP_DEQ, '0);
      drain("t1");
      chk("t1_nres", 32'(got_res.size()), 32'd3);
      if (got_res.size() == 3) begin
         chk("t1_key0", 32'(got_res[0].key), 32'd2);
         chk("t1_key1", 32'(got_res[1].key), 32'd5);
         chk("t1_key2", 32'(got_res[2].key), 32'd9);
      end
      chk("t1_no_err", 32'(n_err), 32'd0);

      // 2: DEQ into empty core
      got_res.delete();
      base = n_deq;
      cmd(OP_DEQ, '0);
      drain("t2");
      chk("t2_err_once", 32'(n_err), 32'd1);
      chk("t2_no_deq", 32'(n_deq - base), 32'd0);
      chk("t2_res_valid", 32'(res_valid), 32'd0);
      chk("t2_nres", 32'(got_res.size()), 32'd0);

      // 3: full core stalls the head ENQ, a DEQ behind it cannot pass
      got_res.delete();
      for (int k = 10; k < 14; k++) cmd(OP_ENQ, mk(k, k + 1));
      drain("t3a");
      chk("t3_full", 32'(pq_full), 32'd1);
      base = n_enq;
      cmd(OP_ENQ, mk(1, 8'h11));
      cmd(OP_DEQ, '0);
      cycles(30);
      chk("t3_stall_enq", 32'(n_enq - base), 32'd0);
      chk("t3_blocked_deq", 32'(n_deq), 32'(exp_deq - 1));
      full_ovr = 1'b1;
      drain("t3b");
      full_ovr = 1'b0;
      chk("t3_enq_issued", 32'(n_enq - base), 32'd1);
      if (got_res.size() == 1) chk("t3_deq_key", 32'(got_res[0].key), 32'd1);
      else chk("t3_nres", 32'(got_res.size()), 32'd1);

      // 4: result backpressure holds the second DEQ
      rr_val = 1'b0;
      cycles(2);
      base = n_deq;
      cmd(OP_DEQ, '0);
      cmd(OP_DEQ, '0);
      cycles(30);
      chk("t4_one_deq", 32'(n_deq - base), 32'd1);
      chk("t4_res_valid", 32'(res_valid), 32'd1);
      chk("t4_res_key", 32'(res_kv.key), 32'd10);
      rr_val = 1'b1;
      rr_cyc = cyc;
      drain("t4");
      chk("t4_two_deq", 32'(n_deq - base), 32'd2);
      chk("t4_gap", 32'(last_deq_cyc > rr_cyc), 32'd1);

      // 5: REPLACE returns the old top
      cmd(OP_DEQ, '0);
      cmd(OP_DEQ, '0);
      drain("t5a");
      got_res.delete();
      base = n_rep;
      cmd(OP_ENQ, mk(3, 8'h33));
      cmd(OP_REP, mk(7, 8'h77));
      drain("t5b");
      chk("t5_rep_once", 32'(n_rep - base), 32'd1);
      if (got_res.size() == 1) chk("t5_old_top", 32'(got_res[0].key), 32'd3);
      else chk("t5_nres", 32'(got_res.size()), 32'd1);
      chk("t5_kvi_held", {16'd0, pq_kvi}, {16'd0, mk(7, 8'h77)});
      cmd(OP_DEQ, '0);
      drain("t5c");

      // 6: asynchronous reset while waiting on the core with a loaded FIFO
      lat_min = 40;
      lat_max = 40;
      cmd(OP_ENQ, mk(20, 1));
      cmd(OP_ENQ, mk(21, 2));
      cmd(OP_ENQ, mk(22, 3));
      cmd(OP_ENQ, mk(23, 4));
      cycles(4);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_res_valid", 32'(res_valid), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_strobes", 32'(pq_enq) + 32'(pq_deq) + 32'(pq_replace), 32'd0);
      chk("t6_pq_kvi", {16'd0, pq_kvi}, 32'd0);
      chk("t6_res_kv", {16'd0, res_kv}, 32'd0);
      ref_q.delete();
      exp_kvi.delete();
      exp_res.delete();
      lat_min = 0;
      lat_max = 3;
      cycles(2);
      #2;
      rst = 1'b0;
      cycles(1);
      exp_enq = n_enq; exp_deq = n_deq; exp_rep = n_rep; exp_err = n_err;
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      base = n_enq + n_deq + n_rep + n_err;
      cycles(15);
      chk("t6_quiet", 32'(n_enq + n_deq + n_rep + n_err - base), 32'd0);

      // randomized stream with random result backpressure
      rand_rr = 1'b1;
      for (int i = 0; i < 200; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      op = OP_NOP;
         else if (r <= 4) op = OP_ENQ;
         else if (r <= 7) op = OP_DEQ;
         else             op = OP_REP;
         if (op == OP_ENQ && ref_q.size() >= CAP) op = OP_DEQ;
         cmd(op, mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 255))));
      end
      rand_rr = 1'b0;
      rr_val = 1'b1;
      drain("rnd");
      chk("rnd_res_left", 32'(exp_res.size()), 32'd0);
      chk("rnd_kvi_left", 32'(exp_kvi.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
